// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// instruction fetch path and the data load/store path. Arbitration happens
// every cycle. Grants are combinational from the requests and registered
// state. Read responses are routed back using a registered owner tag, one
// cycle after the grant.
//
// Arbitration policy (compile-time option, macro FAIR_ARB_EN):
//   undefined : data has fixed priority. A starvation counter forces fetch to
//               win after STARVE_LIMIT consecutive lost conflicts.
//   defined   : round-robin. On a conflict the port that was not granted
//               last time wins. No starvation counter is built.
//
// Parameters
//   ADDR_W        byte-address width
//   DATA_W        data width
//   STARVE_LIMIT  lost conflicts before fetch is forced to win (>= 1)
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   if_req_in / if_addr_in          fetch read request and byte address
//   if_gnt_out                      fetch request accepted this cycle
//   if_rvalid_out / if_rdata_out    fetch read response
//   d_req_in / d_we_in              data request, 1 = store, 0 = load
//   d_addr_in / d_wdata_in          data byte address and store data
//   d_gnt_out                       data request accepted this cycle
//   d_rvalid_out / d_rdata_out      load response
//   mem_addr_out / mem_we_out       SRAM address and write enable
//   mem_din_out / mem_dout_in       SRAM write data and read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_gnt_out,
  output logic              if_rvalid_out,
  output logic [DATA_W-1:0] if_rdata_out,
  input  logic              d_req_in,
  input  logic              d_we_in,
  input  logic [ADDR_W-1:0] d_addr_in,
  input  logic [DATA_W-1:0] d_wdata_in,
  output logic              d_gnt_out,
  output logic              d_rvalid_out,
  output logic [DATA_W-1:0] d_rdata_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_we_out,
  output logic [DATA_W-1:0] mem_din_out,
  input  logic [DATA_W-1:0] mem_dout_in
);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_own_t;

  rsp_own_t rsp_own_q;
  logic     fetch_wins;

`ifdef FAIR_ARB_EN

  typedef enum logic {
    LAST_IF = 1'b0,
    LAST_D  = 1'b1
  } last_t;

  last_t last_q;

  // On a conflict, the port that did not win the previous grant goes first.
  assign fetch_wins = if_req_in & (~d_req_in | (last_q == LAST_D));

  // Remember which port received the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LAST_IF;
    end else if (if_gnt_out) begin
      last_q <= LAST_IF;
    end else if (d_gnt_out) begin
      last_q <= LAST_D;
    end
  end

`else

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q;
  logic             starve_force;

  assign starve_force = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // Data normally wins a conflict; the saturated counter hands one win to fetch.
  assign fetch_wins = if_req_in & (~d_req_in | starve_force);

  // Count consecutive fetch losses; any fetch grant clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else if (if_gnt_out) begin
      starve_cnt_q <= '0;
    end else if (if_req_in && d_req_in && !starve_force) begin
      starve_cnt_q <= starve_cnt_q + CNT_W'(1);
    end
  end

`endif

  assign if_gnt_out = fetch_wins;
  assign d_gnt_out  = d_req_in & ~fetch_wins;

  // Only the granted port drives the SRAM; idle cycles present all zeros.
  always_comb begin
    mem_addr_out = '0;
    mem_din_out  = '0;
    mem_we_out   = 1'b0;
    if (if_gnt_out) begin
      mem_addr_out = if_addr_in;
    end else if (d_gnt_out) begin
      mem_addr_out = d_addr_in;
      mem_din_out  = d_wdata_in;
      mem_we_out   = d_we_in;
    end
  end

  // Tag the owner of next cycle's SRAM read data. Stores return nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_own_q <= RSP_NONE;
    end else if (if_gnt_out) begin
      rsp_own_q <= RSP_IF;
    end else if (d_gnt_out && !d_we_in) begin
      rsp_own_q <= RSP_D;
    end else begin
      rsp_own_q <= RSP_NONE;
    end
  end

  assign if_rvalid_out = (rsp_own_q == RSP_IF);
  assign d_rvalid_out  = (rsp_own_q == RSP_D);
  assign if_rdata_out  = mem_dout_in;
  assign d_rdata_out   = mem_dout_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Testbench for mem_arbiter with a behavioural 4 KB write-first SRAM attached.
// A reference model tracks the expected grant winner, the expected response
// owner, and a shadow copy of memory contents. All DUT outputs are compared
// against that model each cycle. Directed scenarios run first, followed by
// randomized requesters that hold their request until it is granted.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_in    (if_req),
    .if_addr_in   (if_addr),
    .if_gnt_out   (if_gnt),
    .if_rvalid_out(if_rvalid),
    .if_rdata_out (if_rdata),
    .d_req_in     (d_req),
    .d_we_in      (d_we),
    .d_addr_in    (d_addr),
    .d_wdata_in   (d_wdata),
    .d_gnt_out    (d_gnt),
    .d_rvalid_out (d_rvalid),
    .d_rdata_out  (d_rdata),
    .mem_addr_out (mem_addr),
    .mem_we_out   (mem_we),
    .mem_din_out  (mem_din),
    .mem_dout_in  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: 1024 words, one-cycle read latency, write-first.
  logic [DATA_W-1:0] sram [0:1023];

  always @(posedge clk) begin
    if (mem_we) begin
      sram[mem_addr[11:2]] <= mem_din;
      mem_dout             <= mem_din;
    end else begin
      mem_dout <= sram[mem_addr[11:2]];
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] shadow [0:1023];
  int                losses;
  bit                last_was_d;
  int                prev_kind;
  logic [DATA_W-1:0] prev_data;
  bit                exp_if;
  bit                exp_d;

  int assertions;
  int failures;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel();
    losses     = 0;
    last_was_d = 1'b0;
    prev_kind  = 0;
    prev_data  = '0;
  endtask

  // Drive one cycle of requests, check every DUT output against the model,
  // then advance the model across the coming clock edge.
  task automatic applyStimulus(input bit ir, input logic [ADDR_W-1:0] ia,
                               input bit dr, input bit dw,
                               input logic [ADDR_W-1:0] da,
                               input logic [DATA_W-1:0] dd);
    bit fetch_first;
    @(negedge clk);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dd;
    #1;
`ifdef FAIR_ARB_EN
    fetch_first = last_was_d;
`else
    fetch_first = (losses >= STARVE_LIMIT);
`endif
    exp_if = ir && (!dr || fetch_first);
    exp_d  = dr && !exp_if;

    checkOutput("if_gnt", {31'b0, if_gnt}, {31'b0, exp_if});
    checkOutput("d_gnt", {31'b0, d_gnt}, {31'b0, exp_d});
    checkOutput("mem_we", {31'b0, mem_we}, {31'b0, exp_d && dw});
    checkOutput("mem_addr", mem_addr, exp_if ? ia : (exp_d ? da : '0));
    checkOutput("mem_din", mem_din, exp_d ? dd : '0);
    checkOutput("if_rvalid", {31'b0, if_rvalid}, {31'b0, prev_kind == 1});
    checkOutput("d_rvalid", {31'b0, d_rvalid}, {31'b0, prev_kind == 2});
    if (prev_kind == 1) checkOutput("if_rdata", if_rdata, prev_data);
    if (prev_kind == 2) checkOutput("d_rdata", d_rdata, prev_data);

    if (exp_if) losses = 0;
    else if (ir && dr && losses < STARVE_LIMIT) losses++;
    if (exp_if) last_was_d = 1'b0;
    else if (exp_d) last_was_d = 1'b1;

    prev_kind = 0;
    if (exp_if) begin
      prev_kind = 1;
      prev_data = shadow[ia[11:2]];
    end else if (exp_d && !dw) begin
      prev_kind = 2;
      prev_data = shadow[da[11:2]];
    end else if (exp_d && dw) begin
      shadow[da[11:2]] = dd;
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  bit                if_pend, d_pend, d_pwe;
  logic [ADDR_W-1:0] if_paddr, d_paddr;
  logic [DATA_W-1:0] d_pwdata;

  initial begin
    assertions = 0;
    failures   = 0;
    for (int i = 0; i < 1024; i++) begin
      sram[i]   = 32'h1000_0000 + i;
      shadow[i] = 32'h1000_0000 + i;
    end
    resetModel();
    rst_n   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    #1;
    checkOutput("reset_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    checkOutput("reset_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] idle cycles");
    for (int i = 0; i < 3; i++) idleCycle();

    $display("[TB] fetch-only stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0, '0, '0);
    idleCycle();

    $display("[TB] load and fetch held together");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h100, '0);
`ifndef FAIR_ARB_EN
      if (i == 3) checkOutput("starve_d_wins_4th", {31'b0, d_gnt}, 32'd1);
      if (i == 4) checkOutput("starve_if_wins_5th", {31'b0, if_gnt}, 32'd1);
      if (i == 5) checkOutput("starve_d_wins_6th", {31'b0, d_gnt}, 32'd1);
`else
      checkOutput("rr_alternate", {31'b0, d_gnt}, {31'b0, (i % 2) == 0});
`endif
    end
    idleCycle();

    $display("[TB] store then load same address");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h200, '0);
    #1;
    checkOutput("store_load_data", d_rdata, 32'hDEADBEEF);
    idleCycle();

    $display("[TB] reset during in-flight fetch");
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    if_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("rst_drop_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) idleCycle();
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, '0, '0);
    idleCycle();

    $display("[TB] randomized traffic");
    if_pend = 1'b0;
    d_pend  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!if_pend && ($urandom_range(99) < 60)) begin
        if_pend  = 1'b1;
        if_paddr = {20'h0, 5'h0, 5'($urandom_range(31)), 2'b00};
      end
      if (!d_pend && ($urandom_range(99) < 60)) begin
        d_pend   = 1'b1;
        d_pwe    = ($urandom_range(1) == 1);
        d_paddr  = {20'h0, 5'h0, 5'($urandom_range(31)), 2'b00};
        d_pwdata = $urandom;
      end
      applyStimulus(if_pend, if_pend ? if_paddr : 32'h0, d_pend, d_pend && d_pwe,
                    d_pend ? d_paddr : 32'h0, d_pend ? d_pwdata : 32'h0);
      if (exp_if) if_pend = 1'b0;
      if (exp_d) d_pend = 1'b0;
    end
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
